// File: rtl/exp_seq_if.sv
// exp_seq control interface: start/op request, decoder feedback, and the
// expfunc/safunc code outputs with their look-ahead fields.
interface exp_seq_if;
    logic       start;
    logic [1:0] op;
    logic       fpuhold;
    logic       le;
    logic       topsign;
    logic       round_ovf;
    logic       busy;
    logic       done;
    logic       expovf;
    logic       ae_small;
    logic [3:0] expfunc;
    logic [2:0] safunc;
    logic [3:0] nx_expfunc_rom0;
    logic [3:0] nx_expfunc_rom1;
    logic [1:0] romsel;

    // Sequencer side.
    modport slave (
        input  start, op, fpuhold, le, topsign, round_ovf,
        output busy, done, expovf, ae_small, expfunc, safunc,
        output nx_expfunc_rom0, nx_expfunc_rom1, romsel
    );

    // Requester / decoder side.
    modport master (
        output start, op, fpuhold, le, topsign, round_ovf,
        input  busy, done, expovf, ae_small, expfunc, safunc,
        input  nx_expfunc_rom0, nx_expfunc_rom1, romsel
    );
endinterface

// File: rtl/exp_seq.sv
// exp_seq: exponent-datapath microsequencer. Steps a fixed per-op sequence,
// driving registered expfunc/safunc codes plus combinational look-ahead
// (nx_expfunc_rom0/rom1, romsel) one cycle ahead of expfunc.
// Optional feature macro: EXP_SEQ_ROUND_INC_EN enables the RND branch on
// round_ovf (aexp++); without it RND always emits (0, 7).
module exp_seq (
    input logic      clk,
    input logic      reset,
    exp_seq_if.slave bus
);
    typedef enum logic [3:0] {
        StIdle, StCmp, StAlign, StNorm, StRnd, StEadd, StOvchk, StCvld, StFin
    } state_e;

    localparam logic [1:0] OpAdd = 2'd0;
    localparam logic [1:0] OpMul = 2'd1;
    localparam logic [1:0] OpCmp = 2'd2;

    state_e     r_state;
    state_e     w_next;
    logic [1:0] r_op;
    logic       r_busy;
    logic       r_done;
    logic       r_expovf;
    logic       r_ae_small;
    logic [3:0] r_expfunc;
    logic [2:0] r_safunc;
    logic       w_accept;
    logic       w_br_path;
    logic       w_br_taken;

    function automatic logic [3:0] ef_of(input state_e s, input logic inc);
        case (s)
            StCmp:   ef_of = 4'h7;
            StAlign: ef_of = 4'h3;
            StNorm:  ef_of = 4'h4;
            StRnd:   ef_of = inc ? 4'hf : 4'h0;
            StEadd:  ef_of = 4'h6;
            StOvchk: ef_of = 4'he;
            StCvld:  ef_of = 4'h1;
            default: ef_of = 4'h0;
        endcase
    endfunction

    function automatic logic [2:0] sf_of(input state_e s);
        case (s)
            StAlign: sf_of = 3'd2;
            StNorm:  sf_of = 3'd5;
            StRnd:   sf_of = 3'd7;
            StOvchk: sf_of = 3'd7;
            StCvld:  sf_of = 3'd4;
            default: sf_of = 3'd0;
        endcase
    endfunction

    // Next-state decode and the branch path (only NORM within ADD can branch).
    always_comb begin
        w_accept = (r_state == StIdle) && bus.start && !bus.fpuhold;
`ifdef EXP_SEQ_ROUND_INC_EN
        w_br_path = (r_state == StNorm) && (r_op == OpAdd);
`else
        w_br_path = 1'b0;
`endif
        w_br_taken = w_br_path && bus.round_ovf;
        w_next     = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    case (bus.op)
                        OpAdd, OpCmp: w_next = StCmp;
                        OpMul:        w_next = StEadd;
                        default:      w_next = StCvld;
                    endcase
                end
            end
            StCmp:   w_next = (r_op == OpCmp) ? StFin : StAlign;
            StAlign: w_next = StNorm;
            StNorm:  w_next = (r_op == OpAdd) ? StRnd : StFin;
            StRnd:   w_next = StFin;
            StEadd:  w_next = StOvchk;
            StOvchk: w_next = StNorm;
            StCvld:  w_next = StNorm;
            default: w_next = StIdle;
        endcase
    end

    // Look-ahead fields predict the expfunc that the next edge will register.
    always_comb begin
        bus.nx_expfunc_rom0 = ef_of(w_next, 1'b0);
        bus.nx_expfunc_rom1 = w_br_path ? 4'hf : ef_of(w_next, 1'b0);
        if (w_next == StFin || w_next == StIdle) begin
            bus.romsel = 2'd2;
        end else if (w_br_taken) begin
            bus.romsel = 2'd1;
        end else begin
            bus.romsel = 2'd0;
        end
    end

    // Sequencer state, registered codes and status flags; fpuhold freezes all.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_op       <= 2'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_expovf   <= 1'b0;
            r_ae_small <= 1'b0;
            r_expfunc  <= 4'h0;
            r_safunc   <= 3'd0;
        end else if (!bus.fpuhold) begin
            r_state   <= w_next;
            r_expfunc <= ef_of(w_next, w_br_taken);
            r_safunc  <= sf_of(w_next);
            r_busy    <= (w_next != StIdle) && (w_next != StFin);
            // done marks the cycle after FIN, i.e. the sequence has retired.
            r_done    <= (r_state == StFin);
            if (w_accept) begin
                r_op       <= bus.op;
                r_expovf   <= 1'b0;
                r_ae_small <= 1'b0;
            end
            if (r_state == StOvchk) begin
                r_expovf <= bus.le;
            end
            if (r_state == StCmp && r_op == OpCmp) begin
                r_ae_small <= bus.topsign;
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.expovf   = r_expovf;
    assign bus.ae_small = r_ae_small;
    assign bus.expfunc  = r_expfunc;
    assign bus.safunc   = r_safunc;
endmodule

// File: tb/tb_exp_seq.sv
// Bench for exp_seq: sequence-table reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_exp_seq;
`ifdef EXP_SEQ_ROUND_INC_EN
    localparam bit RIE = 1'b1;
`else
    localparam bit RIE = 1'b0;
`endif
    // Step identifiers used by the model's sequence tables.
    localparam int S_IDLE = 0, S_CMP = 1, S_ALIGN = 2, S_NORM = 3, S_RND = 4;
    localparam int S_EADD = 5, S_OVCHK = 6, S_CVLD = 7, S_FIN = 8;

    logic clk = 1'b0;
    logic reset;
    exp_seq_if bus ();
    exp_seq dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Per-op step lists and per-step codes, straight from the operation tables.
    int seq [4][5] = '{'{S_CMP, S_ALIGN, S_NORM, S_RND, S_FIN},
                       '{S_EADD, S_OVCHK, S_NORM, S_FIN, S_IDLE},
                       '{S_CMP, S_FIN, S_IDLE, S_IDLE, S_IDLE},
                       '{S_CVLD, S_NORM, S_FIN, S_IDLE, S_IDLE}};
    int len [4] = '{5, 4, 2, 3};
    int ef_tab [9] = '{0, 7, 3, 4, 0, 6, 14, 1, 0};
    int sf_tab [9] = '{0, 0, 2, 5, 7, 0, 7, 4, 0};

    bit m_active, m_done, m_expovf, m_ae, m_br;
    int m_op, m_idx;

    logic [3:0] d_ef [10];
    logic       d_done [10];
    logic [1:0] d_romsel [10];
    logic       d_busy [10];
    logic       d_expovf [10];
    logic       d_ae [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_init;
        m_active = 0; m_done = 0; m_expovf = 0; m_ae = 0; m_br = 0; m_op = 0; m_idx = 0;
    endtask

    task automatic m_step;
        int s;
        if (bus.fpuhold) return;
        m_done = 0;
        if (!m_active) begin
            if (bus.start) begin
                m_active = 1; m_op = int'(bus.op); m_idx = 0;
                m_expovf = 0; m_ae = 0; m_br = 0;
            end
        end else begin
            s = seq[m_op][m_idx];
            if (s == S_NORM && m_op == 0) m_br = RIE && bus.round_ovf;
            if (s == S_OVCHK) m_expovf = bus.le;
            if (s == S_CMP && m_op == 2) m_ae = bus.topsign;
            if (m_idx == len[m_op] - 1) begin
                m_active = 0; m_done = 1;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic m_check;
        int cur, nxt, rom0, rom1, rs, ef;
        bit brp;
        cur = m_active ? seq[m_op][m_idx] : S_IDLE;
        ef  = (cur == S_RND && m_br) ? 15 : ef_tab[cur];
        if (!m_active) nxt = (bus.start && !bus.fpuhold) ? seq[bus.op][0] : S_IDLE;
        else nxt = (m_idx == len[m_op] - 1) ? S_IDLE : seq[m_op][m_idx + 1];
        brp  = m_active && cur == S_NORM && m_op == 0 && RIE;
        rom0 = ef_tab[nxt];
        rom1 = brp ? 15 : rom0;
        rs   = (nxt == S_FIN || nxt == S_IDLE) ? 2 : ((brp && bus.round_ovf) ? 1 : 0);
        chk("busy", bus.busy, m_active && cur != S_FIN);
        chk("done", bus.done, m_done);
        chk("expovf", bus.expovf, m_expovf);
        chk("ae_small", bus.ae_small, m_ae);
        chk("expfunc", bus.expfunc, ef);
        chk("safunc", bus.safunc, sf_tab[cur]);
        chk("nx_rom0", bus.nx_expfunc_rom0, rom0);
        chk("nx_rom1", bus.nx_expfunc_rom1, rom1);
        chk("romsel", bus.romsel, rs);
    endtask

    // Compare process: model advances on the edge, everything checked mid-cycle.
    initial begin
        m_init();
        forever begin
            @(posedge clk);
            if (!reset) m_step();
            @(negedge clk);
            if (reset) m_init();
            m_check();
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Issue one op with constant feedback; record outputs after edges 0..9.
    task automatic directed(input logic [1:0] o, input logic ro, input logic l,
                            input logic ts, input int restart_k, input int hold_lo,
                            input int hold_hi);
        tick();
        bus.start = 1'b1; bus.op = o; bus.round_ovf = ro; bus.le = l;
        bus.topsign = ts; bus.fpuhold = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            d_ef[k] = bus.expfunc; d_done[k] = bus.done; d_romsel[k] = bus.romsel;
            d_busy[k] = bus.busy; d_expovf[k] = bus.expovf; d_ae[k] = bus.ae_small;
            bus.start   = (k == restart_k);
            bus.fpuhold = (k >= hold_lo && k <= hold_hi);
        end
        bus.start = 1'b0; bus.fpuhold = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 0; bus.op = 0; bus.fpuhold = 0; bus.le = 0; bus.topsign = 0;
        bus.round_ovf = 0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("idle_busy", bus.busy, 0);
        chk("idle_romsel", bus.romsel, 2);
        chk("idle_expfunc", bus.expfunc, 0);

        // ADD with round carry in NORM.
        directed(2'd0, 1'b1, 1'b0, 1'b0, -1, 99, -1);
        chk("add_ef0", d_ef[0], 7);
        chk("add_ef1", d_ef[1], 3);
        chk("add_ef2", d_ef[2], 4);
        chk("add_ef3", d_ef[3], RIE ? 15 : 0);
        chk("add_ef4", d_ef[4], 0);
        chk("add_romsel_norm", d_romsel[2], RIE ? 1 : 0);
        chk("add_done4", d_done[4], 0);
        chk("add_done5", d_done[5], 1);
        chk("add_done6", d_done[6], 0);

        // MUL with le=1 in OVCHK.
        directed(2'd1, 1'b0, 1'b1, 1'b0, -1, 99, -1);
        chk("mul_ef0", d_ef[0], 6);
        chk("mul_ef1", d_ef[1], 14);
        chk("mul_ef2", d_ef[2], 4);
        chk("mul_ef3", d_ef[3], 0);
        chk("mul_done3", d_done[3], 0);
        chk("mul_done4", d_done[4], 1);
        chk("mul_expovf", d_expovf[4], 1);

        // CMP with topsign=1 and a second start issued while in CMP.
        directed(2'd2, 1'b0, 1'b0, 1'b1, 0, 99, -1);
        chk("cmp_ef0", d_ef[0], 7);
        chk("cmp_done2", d_done[2], 1);
        chk("cmp_ae_small", d_ae[2], 1);
        chk("cmp_ignored_busy", d_busy[3], 0);
        chk("cmp_ignored_ef", d_ef[3], 0);

        // CVT with fpuhold for three cycles during NORM.
        directed(2'd3, 1'b0, 1'b0, 1'b0, -1, 1, 3);
        chk("cvt_ef0", d_ef[0], 1);
        for (int k = 1; k <= 4; k++) chk("cvt_hold_ef", d_ef[k], 4);
        chk("cvt_ef5", d_ef[5], 0);
        chk("cvt_done5", d_done[5], 0);
        chk("cvt_done6", d_done[6], 1);

        // Reset pulsed during ALIGN of ADD, then a fresh ADD.
        tick();
        bus.start = 1'b1; bus.op = 2'd0;
        tick();
        bus.start = 1'b0;
        tick();
        chk("rst_align_ef", bus.expfunc, 3);
        reset = 1'b1;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_ef", bus.expfunc, 0);
        chk("rst_romsel", bus.romsel, 2);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rst_no_done", bus.done, 0);
        end
        directed(2'd0, 1'b0, 1'b0, 1'b0, -1, 99, -1);
        chk("add2_ef0", d_ef[0], 7);
        chk("add2_ef3", d_ef[3], 0);
        chk("add2_done5", d_done[5], 1);

        // Randomized traffic; model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
            end
            bus.start     = ($urandom_range(0, 3) == 0);
            bus.op        = 2'($urandom_range(0, 3));
            bus.fpuhold   = ($urandom_range(0, 7) == 0);
            bus.le        = 1'($urandom);
            bus.topsign   = 1'($urandom);
            bus.round_ovf = 1'($urandom);
        end
        reset = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
